// File: rtl/bus_ctrl.sv
// Single-outstanding bus initiator: request -> strobes -> ack/timeout -> response. rsp_valid at T+2 (zero-wait), T+2+N (N waits).
// Backpressure: holds the response until rsp_ready; req_ready only in IDLE, so no new request is taken while a response is pending.
module bus_ctrl #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [15:0]     req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            bus_rd,
  output logic            bus_wr,
  output logic [15:0]     bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic            dec_hit,
  input  logic [2:0]      dec_did,
  input  logic [6:0]      dev_ack,
  input  logic [7*DW-1:0] dev_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_err,
  output logic [7:0]      err_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic            bus_rd_nx, bus_wr_nx;
  logic [15:0]     bus_addr_nx;
  logic [DW-1:0]   bus_wdata_nx;
  logic            rsp_valid_nx;
  logic [DW-1:0]   rsp_rdata_nx;
  logic [1:0]      rsp_err_nx;
  logic [7:0]      err_cnt_nx;
  logic [2:0]      did_q, did_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  logic            done;
  logic [1:0]      done_err;
  logic [2:0]      done_did;

  // ID 7 (NONE) has no device behind it: pad so it reads as no-ack, zero data.
  logic [7:0]      ack_ext;
  logic [DW-1:0]   rdata_arr [8];

  assign ack_ext = {1'b0, dev_ack};

  for (genvar i = 0; i < 7; i++) begin : g_slice
    assign rdata_arr[i] = dev_rdata[i*DW +: DW];
  end
  assign rdata_arr[7] = '0;

  assign req_ready = (state == IDLE);

  always_comb begin
    state_nx     = state;
    bus_rd_nx    = bus_rd;
    bus_wr_nx    = bus_wr;
    bus_addr_nx  = bus_addr;
    bus_wdata_nx = bus_wdata;
    rsp_valid_nx = rsp_valid;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    err_cnt_nx   = err_cnt;
    did_nx       = did_q;
    cnt_nx       = cnt;
    done         = 1'b0;
    done_err     = 2'b00;
    done_did     = 3'd0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          bus_addr_nx  = req_addr;
          bus_wdata_nx = req_wdata;
          bus_rd_nx    = ~req_wr;
          bus_wr_nx    = req_wr;
          state_nx     = ISSUE;
        end
      end
      ISSUE: begin
        if (!dec_hit) begin
          done     = 1'b1;
          done_err = 2'b01;
        end else if (ack_ext[dec_did]) begin
          done     = 1'b1;
          done_did = dec_did;
        end else begin
          did_nx   = dec_did;
          cnt_nx   = '0;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // Ack beats timeout when both land in the same cycle.
        if (ack_ext[did_q]) begin
          done     = 1'b1;
          done_did = did_q;
        end else if (cnt == CNT_LAST) begin
          done     = 1'b1;
          done_err = 2'b10;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (done) begin
      bus_rd_nx    = 1'b0;
      bus_wr_nx    = 1'b0;
      rsp_valid_nx = 1'b1;
      rsp_err_nx   = done_err;
      rsp_rdata_nx = (done_err == 2'b00 && !bus_wr) ? rdata_arr[done_did] : '0;
      state_nx     = RESP;
      if (done_err != 2'b00 && err_cnt != 8'hFF) err_cnt_nx = err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
      err_cnt   <= 8'd0;
      did_q     <= 3'd0;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      bus_rd    <= bus_rd_nx;
      bus_wr    <= bus_wr_nx;
      bus_addr  <= bus_addr_nx;
      bus_wdata <= bus_wdata_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      err_cnt   <= err_cnt_nx;
      did_q     <= did_nx;
      cnt       <= cnt_nx;
    end
  end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Single-outstanding memory-bus initiator between the core's load/store request port and the memory-mapped device fabric.
- Drives rd/wr/addr/wdata onto the shared bus and consumes hit/did from the central address decoder.
- Waits for the selected device's acknowledge, or times out, then returns read data and an error code to the requester through a valid/ready response channel.
- Device IDs: RAM=0, ROM=1, MAT=2, INT=3, REG=4, EXEC=5, SPI=6, NONE=7.

Parameters:
- DW, 16, data bus width in bits.
- TIMEOUT, 16, number of WAIT cycles before a transaction is abandoned. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  16  byte address.
- req_wdata  in  DW  write data.
- bus_rd  out  1  read strobe to decoder and devices.
- bus_wr  out  1  write strobe to decoder and devices.
- bus_addr  out  16  address to decoder and devices.
- bus_wdata  out  DW  write data to devices.
- dec_hit  in  1  decoder hit, combinational from bus_rd/bus_wr/bus_addr.
- dec_did  in  3  decoder device ID.
- dev_ack  in  7  per-device acknowledge, bit i = device ID i.
- dev_rdata  in  7*DW  per-device read data. Slice i = bits [i*DW +: DW].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  DW  read data. 0 for writes and errors.
- rsp_err  out  2  00=ok, 01=decode miss, 10=timeout, 11 unused.
- err_cnt  out  8  saturating count of errored transactions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State=IDLE.
  - bus_rd=0, bus_wr=0, bus_addr=0, bus_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=00, err_cnt=0.
  - req_ready=(state==IDLE), so it reads 1.
  - All inputs are ignored while rst_n is low.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except req_ready.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: capture wr, addr, wdata. Load bus_addr/bus_wdata. Set bus_rd=~wr and bus_wr=wr. Go to ISSUE.
- ISSUE (one cycle, strobes high):
  - dec_hit=0: drop strobes, rsp_err=01, rsp_rdata=0, go to RESP.
  - dec_hit=1 and dev_ack[dec_did]=1: complete with err=00.
  - dec_hit=1, no ack: latch did_q=dec_did, clear the timeout counter, go to WAIT.
- WAIT:
  - Strobes, bus_addr and bus_wdata held stable. Counter increments each cycle.
  - dev_ack[did_q]=1: complete with err=00.
  - Else, if counter==TIMEOUT-1: drop strobes, rsp_err=10, rsp_rdata=0, go to RESP.
  - Ack and the timeout condition in the same cycle: the ack wins (err=00).
  - Acks from non-selected devices are ignored in ISSUE and WAIT.
- Complete (ok):
  - rsp_rdata = read ? dev_rdata slice[did] : 0.
  - Drop strobes, go to RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- err_cnt increments once per transaction entering RESP with rsp_err≠00, and saturates at 255.
- Latency, request accepted at edge T:
  - Strobes high from T+1.
  - Zero-wait ack gives rsp_valid at T+2.
  - N-cycle ack gives rsp_valid at T+2+N.
  - Timeout: strobes high for 1+TIMEOUT cycles, rsp_valid at T+2+TIMEOUT.
- Reset mid-transaction: strobes and rsp_valid drop asynchronously. The transaction is discarded with no response and no err_cnt update.
- Timeout counter width is $clog2(TIMEOUT+1). The counter never wraps.

Test Plan:
1. Zero-wait read:
   - Stimulus: read 0x0123; dev_ack[0]=1 during ISSUE with slice0=0xBEEF.
   - Required: bus_rd high for 1 cycle; rsp_valid at T+2; rsp_rdata=0xBEEF; rsp_err=00.
2. Wait-state write:
   - Stimulus: write 0xA5A5 to 0x6004; dev_ack[6] asserted on the 3rd WAIT cycle.
   - Required: bus_wr high for 4 cycles; bus_wdata=0xA5A5 stable throughout; rsp_rdata=0; rsp_err=00.
3. Decode miss:
   - Stimulus: read 0x8000 (dec_hit=0).
   - Required: strobes high for 1 cycle; rsp_valid at T+2; rsp_err=01; err_cnt=1.
4. Timeout with wrong-device ack:
   - Stimulus: read 0x2010, TIMEOUT=16; only dev_ack[3] pulses.
   - Required: bus_rd high for 17 cycles; rsp_err=10; rsp_rdata=0; err_cnt increments.
   - Repeat with dev_ack[2] on the last WAIT cycle. Required: rsp_err=00.
5. Response backpressure:
   - Stimulus: rsp_ready held low for 5 cycles; req_valid held high.
   - Required: response fields constant; req_ready=0; next request accepted only after the handshake.
6. Reset cases:
   - Stimulus: drop rst_n mid-WAIT.
   - Required: bus_rd=0 and rsp_valid=0 immediately; err_cnt=0; req_ready=1.
   - Stimulus: force 300 decode misses.
   - Required: err_cnt saturates at 255.
